// File: rtl/rf_pkg.sv
// rf_pkg: shared widths and word/address types for the register file
package rf_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH = 2 ** ADDR_W;
  typedef logic [ADDR_W-1:0] rf_addr_t;
  typedef logic [DATA_W-1:0] rf_word_t;
endpackage

// File: rtl/rf_read_port.sv
// rf_read_port: enable-gated registered read port with write-first bypass
module rf_read_port
  import rf_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     en,
  input  rf_addr_t addr,
  input  rf_word_t rd_word,
  input  logic     we,
  input  rf_addr_t waddr,
  input  rf_word_t wdata,
  output rf_word_t q
);
  // a same-cycle write to the read address wins over the stored word
  always_ff @(posedge clk)
    if (rst) q <= '0;
    else if (en) q <= (we && waddr == addr) ? wdata : rd_word;
endmodule

// File: rtl/register_file_32x32.sv
// register_file_32x32: 32x32 flop-array register file, one write port, two registered read ports
module register_file_32x32
  import rf_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] In,
  input  logic [ADDR_W-1:0] address_w,
  input  logic              enable_w,
  input  logic [ADDR_W-1:0] address_a,
  input  logic              enable_a,
  input  logic [ADDR_W-1:0] address_b,
  input  logic              enable_b,
  output logic [DATA_W-1:0] OutA,
  output logic [DATA_W-1:0] OutB
);
  rf_word_t mem [DEPTH];
  // storage: reset clears every entry, otherwise the addressed entry takes In
  always_ff @(posedge clk)
    if (rst) for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    else if (enable_w) mem[address_w] <= In;
  rf_read_port u_port_a (
    .clk(clk), .rst(rst), .en(enable_a), .addr(address_a), .rd_word(mem[address_a]),
    .we(enable_w), .waddr(address_w), .wdata(In), .q(OutA)
  );
  rf_read_port u_port_b (
    .clk(clk), .rst(rst), .en(enable_b), .addr(address_b), .rd_word(mem[address_b]),
    .we(enable_w), .waddr(address_w), .wdata(In), .q(OutB)
  );
endmodule

// File: tb/tb_register_file_32x32.sv
// tb_register_file_32x32: random and directed checks against an array model
module tb_register_file_32x32;
  logic        clk = 0;
  logic        rst;
  logic [31:0] wd;
  logic [4:0]  aw, aa, ab;
  logic        enw, ena, enb;
  logic [31:0] OutA, OutB;
  logic [31:0] mem [32];
  logic [31:0] m_a, m_b;
  logic [31:0] w [32];
  logic [31:0] keep;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  register_file_32x32 dut (
    .clk(clk), .rst(rst), .In(wd), .address_w(aw), .enable_w(enw),
    .address_a(aa), .enable_a(ena), .address_b(ab), .enable_b(enb),
    .OutA(OutA), .OutB(OutB)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    rst = 0; enw = 0; ena = 0; enb = 0;
  endtask

  // advance one edge, update the model from the behavioural rules, then compare both outputs
  task automatic tick(input string tag);
    @(posedge clk);
    if (rst) begin
      foreach (mem[i]) mem[i] = '0;
      m_a = '0;
      m_b = '0;
    end else begin
      if (ena) m_a = (enw && aw == aa) ? wd : mem[aa];
      if (enb) m_b = (enw && aw == ab) ? wd : mem[ab];
      if (enw) mem[aw] = wd;
    end
    #1;
    chk({tag, "_a"}, OutA, m_a);
    chk({tag, "_b"}, OutB, m_b);
  endtask

  initial begin
    foreach (mem[i]) mem[i] = 'x;
    m_a = 'x; m_b = 'x;
    wd = 0; aw = 0; aa = 0; ab = 0;
    idle();
    rst = 1;
    tick("init_rst");
    idle();
    wd = 32'hDEADBEEF; aw = 5; enw = 1;
    tick("wr5");
    idle(); rst = 1;
    tick("rst_pulse");
    idle(); ena = 1; aa = 5; enb = 1; ab = 5;
    tick("rd5_after_rst");
    chk("rst_clears_a", OutA, 32'h0);
    chk("rst_clears_b", OutB, 32'h0);

    idle();
    for (int i = 0; i < 32; i++) begin
      w[i] = $urandom;
      enw = 1; aw = i[4:0]; wd = w[i];
      tick("fill");
    end
    idle();
    for (int i = 0; i < 16; i++) begin
      ena = 1; aa = i[4:0]; enb = 1; ab = 5'(i + 16);
      tick("readback");
      chk("readback_a_w", OutA, w[i]);
      chk("readback_b_w", OutB, w[i + 16]);
    end

    idle(); enw = 1; aw = 4; wd = 32'h12345678;
    tick("set4");
    idle(); ena = 1; aa = 4; enb = 1; ab = 4;
    tick("rd4");
    idle();
    for (int i = 0; i < 3; i++) begin
      aa = $urandom; ab = $urandom; enw = 1; aw = 5'(i + 10); wd = $urandom;
      tick("hold");
      chk("hold_a_const", OutA, 32'h12345678);
      chk("hold_b_const", OutB, 32'h12345678);
    end

    idle(); enw = 1; aw = 7; wd = 32'h11111111;
    tick("set7");
    enw = 1; aw = 7; wd = 32'hAAAAAAAA; ena = 1; aa = 7; enb = 1; ab = 7;
    tick("bypass");
    chk("bypass_a_const", OutA, 32'hAAAAAAAA);
    chk("bypass_b_const", OutB, 32'hAAAAAAAA);

    idle(); wd = 32'hFFFFFFFF; aw = 3;
    repeat (4) tick("wr_off");
    ena = 1; aa = 3;
    tick("rd3");
    chk("wr_off_keep", OutA, w[3]);

    idle(); enw = 1; aw = 9; wd = 32'h0000CAFE; ena = 1; aa = 2; enb = 1; ab = 31;
    tick("concurrent");
    chk("conc_a_w2", OutA, w[2]);
    chk("conc_b_w31", OutB, w[31]);
    idle(); ena = 1; aa = 9;
    tick("rd9");
    chk("conc_w9", OutA, 32'h0000CAFE);

    for (int i = 0; i < 300; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      enw = $urandom; ena = $urandom; enb = $urandom;
      aw = $urandom; aa = $urandom; ab = $urandom; wd = $urandom;
      if ($urandom_range(0, 3) == 0) aa = aw;
      if ($urandom_range(0, 3) == 0) ab = aw;
      tick("rand");
    end

    idle();
    for (int i = 0; i < 32; i++) begin
      ena = 1; aa = i[4:0]; enb = 1; ab = 5'(31 - i);
      tick("final_sweep");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/register_file_32x32.md
Name: register_file_32x32

Overview:
- 32-entry × 32-bit general register file with one synchronous write port and two independent, enable-gated, registered read ports (A and B).
- Sits in the datapath as operand storage. The write port loads results; ports A/B supply two operands per cycle.
- All 32 entries, including address 0, are ordinary read/write storage. There is no hardwired-zero register.

Parameters:
- DATA_W, 32, word width in bits
- ADDR_W, 5, address width in bits
- DEPTH, 32, number of entries (2**ADDR_W)

Ports:
- clk  input  1  system clock; all state changes on its rising edge
- rst  input  1  synchronous, active-high reset
- In  input  DATA_W  write data
- address_w  input  ADDR_W  write address
- enable_w  input  1  write enable
- address_a  input  ADDR_W  read port A address
- enable_a  input  1  read port A enable
- address_b  input  ADDR_W  read port B address
- enable_b  input  1  read port B enable
- OutA  output  DATA_W  read port A data (registered)
- OutB  output  DATA_W  read port B data (registered)

Behaviour:
- Reset: rst=1 at a rising clk clears all 32 entries, OutA and OutB to 0.
  - Reset has priority over write and reads in that cycle.
  - Reset asserted mid-operation discards any write or read presented in that cycle.
- Write: at a rising clk with rst=0 and enable_w=1, entry[address_w] <= In.
  - enable_w=0 leaves all entries unchanged; In and address_w are don't-care.
- Read A: at a rising clk with rst=0 and enable_a=1, OutA <= entry[address_a].
  - One-cycle latency: data is visible after the edge that samples the address.
  - enable_a=0: OutA holds its previous value.
- Read B: identical to read A, using address_b, enable_b and OutB. Ports A and B are fully independent.
- Both read ports may address the same entry in the same cycle; both return the same value.
- Read-during-write to the same address in the same cycle is write-first (bypass).
  - The enabled read port registers the new In value, not the old entry contents.
  - This applies independently to A and B.
- Simultaneous write plus both reads at three different addresses all complete in one cycle.
- All addresses 0..31 are valid; there are no out-of-range cases and no wrap logic.
- No X propagation: outputs are always driven from reset values or stored data.
- Storage is a flip-flop array; synthesis must not infer an asynchronous-read RAM.

Decomposition:
- Shared package rf_pkg holds:
  - constants DATA_W=32, ADDR_W=5, DEPTH=32
  - typedefs rf_addr_t (logic [ADDR_W-1:0]) and rf_word_t (logic [DATA_W-1:0])
- One natural sub-module: rf_read_port.
  - Contains the enable-gated output register with write-first bypass compare.
  - Instantiated twice, once each for A and B.
- The storage array and write decode stay in the top module.

Test Plan:
1. Reset: write 0xDEADBEEF to entry 5, then pulse rst for one cycle. Read A at address 5 with enable_a=1 -> OutA=0; OutB=0.
2. Fill/readback: write random word Wi to entries 0..31 (one per cycle). Then read addresses 0..15 on A and 16..31 on B. Each OutA/OutB equals its Wi one cycle after its address is sampled. Entry 0 returns W0, not 0.
3. Enable hold: set OutA=0x12345678 via a read, then drop enable_a and change address_a. OutA stays 0x12345678 for 3 cycles. The same check applies to B.
4. Write-first bypass: entry 7=0x11111111. In one cycle, write 0xAAAAAAAA to 7 with enable_a=1, address_a=7, enable_b=1, address_b=7. After the edge, OutA=OutB=0xAAAAAAAA.
5. Write disabled: set enable_w=0, In=0xFFFFFFFF, address_w=3 for several cycles. Entry 3 still reads its prior value.
6. Concurrent ports: in one cycle, write 0x0000CAFE to 9, read A at 2 and read B at 31. OutA and OutB show entries 2 and 31; entry 9 reads 0x0000CAFE on the next read.
